// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle logic/add/sub/slt plus iterative
// unsigned shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] imm_y;
  logic [WIDTH-1:0] imm_hi;
  logic             imm_ov;
  logic             imm_dbz;
  logic             is_multi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  function automatic logic signed_ovf(input logic sa, input logic sb,
                                      input logic sr, input logic is_sub);
    if (is_sub) begin
      signed_ovf = (sa != sb) && (sr != sa);
    end else begin
      signed_ovf = (sa == sb) && (sr != sa);
    end
  endfunction

  // Results of the ops that complete at the accepting edge.
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    imm_y    = {WIDTH{1'b0}};
    imm_hi   = {WIDTH{1'b0}};
    imm_ov   = 1'b0;
    imm_dbz  = 1'b0;
    is_multi = 1'b0;
    case (op)
      OP_AND: imm_y = a & b;
      OP_OR:  imm_y = a | b;
      OP_ADD: begin
        imm_y  = sum;
        imm_ov = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        imm_y  = diff;
        imm_ov = signed_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OP_SLT: imm_y = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      OP_MUL: is_multi = 1'b1;
      OP_DIV: begin
        if (b == {WIDTH{1'b0}}) begin
          imm_y   = {WIDTH{1'b1}};
          imm_hi  = a;
          imm_dbz = 1'b1;
        end else begin
          is_multi = 1'b1;
        end
      end
      default: imm_y = {WIDTH{1'b0}};
    endcase
  end

  // One iteration of shift-add multiply or restoring divide on the work registers.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ok   = ~div_diff[WIDTH];
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ok};
    end
  end

  // Control FSM with registered handshake, results and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 3'd0;
      opnd        <= {WIDTH{1'b0}};
      acc_hi      <= {WIDTH{1'b0}};
      acc_lo      <= {WIDTH{1'b0}};
      cnt         <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      y           <= {WIDTH{1'b0}};
      y_hi        <= {WIDTH{1'b0}};
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q        <= op;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            if (is_multi) begin
              state  <= EXEC;
              busy   <= 1'b1;
              cnt    <= {CNT_W{1'b0}};
              acc_hi <= {WIDTH{1'b0}};
              // Multiplier shifts out of acc_lo; dividend shifts out of acc_lo.
              if (op == OP_MUL) begin
                acc_lo <= b;
                opnd   <= a;
              end else begin
                acc_lo <= a;
                opnd   <= b;
              end
            end else begin
              state       <= FIN;
              done        <= 1'b1;
              y           <= imm_y;
              y_hi        <= imm_hi;
              zero        <= (imm_y == {WIDTH{1'b0}});
              overflow    <= imm_ov;
              div_by_zero <= imm_dbz;
            end
          end
        end
        EXEC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt == LAST_ITER) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            y     <= step_lo;
            y_hi  <= step_hi;
            zero  <= (step_lo == {WIDTH{1'b0}});
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
